fp8_add_arbiter: RTL

FP8_ADD_ARBITER -- requirements
Module: fp8_add_arbiter

---
 rtl/fp8_pkg.sv | 10 +
 rtl/fp8_add_core.sv | 24 ++
 rtl/fp8_add_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/fp8_pkg.sv
// fp8_pkg: fp8 field positions, exponent limit and arbiter FSM states
package fp8_pkg;
  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB = 6;
  localparam int EXP_LSB = 3;
  localparam int MANT_MSB = 2;
  localparam int MANT_LSB = 0;
  localparam logic [3:0] EXP_MAX = 4'd15;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/fp8_add_core.sv
// fp8_add_core: combinational fp8 add (no hidden bit), saturating at the top exponent
module fp8_add_core
  import fp8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  logic       a_big;
  logic [7:0] l, s;
  logic [3:0] d, sm, sum;
  // order operands (ties go to b), align the smaller one, add or subtract, then normalise
  always_comb begin
    a_big = a[EXP_MSB:MANT_LSB] > b[EXP_MSB:MANT_LSB];
    l = a_big ? a : b;
    s = a_big ? b : a;
    d = l[EXP_MSB:EXP_LSB] - s[EXP_MSB:EXP_LSB];
    sm = {1'b0, s[MANT_MSB:MANT_LSB]} >> d;
    sum = (l[SIGN_BIT] ^ s[SIGN_BIT]) ? {1'b0, l[MANT_MSB:MANT_LSB]} - sm : {1'b0, l[MANT_MSB:MANT_LSB]} + sm;
    y = !sum[3] ? {l[SIGN_BIT], l[EXP_MSB:EXP_LSB], sum[2:0]} :
        l[EXP_MSB:EXP_LSB] == EXP_MAX ? {l[SIGN_BIT], EXP_MAX, 3'b000} :
        {l[SIGN_BIT], l[EXP_MSB:EXP_LSB] + 4'd1, sum[3:1]};
  end
endmodule

// File: rtl/fp8_add_arbiter.sv
// fp8_add_arbiter: two-port arbitrated fp8 adder, IDLE->EXEC->RESP; FP8_ARB_STATS_EN adds per-port grant counters
module fp8_add_arbiter
  import fp8_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
);
  state_t     state, state_nx;
  logic       last, gnt, acc, op_id;
  logic [7:0] op_a, op_b, sum_y;
  fp8_add_core u_core (.a(op_a), .b(op_b), .y(sum_y));
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // grant selection, handshakes and next state; grant only picks a valid port when one exists
  always_comb begin
    gnt = (req0_valid && req1_valid) ? ((FAIR != 0) ? !last : 1'b0) : req1_valid;
    req0_ready = state == IDLE && !gnt;
    req1_ready = state == IDLE && gnt;
    acc = state == IDLE && (req0_valid || req1_valid);
    rsp_valid = state == RESP;
    busy = state != IDLE;
    state_nx = state == IDLE ? (acc ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  // operand capture on accept, result capture at the end of EXEC
  always_ff @(posedge clk)
    if (!rst_n) begin
      last <= 1'b1;
      op_a <= '0;
      op_b <= '0;
      op_id <= 1'b0;
      rsp_data <= '0;
      rsp_id <= 1'b0;
    end else begin
      if (acc) begin
        op_a <= gnt ? req1_a : req0_a;
        op_b <= gnt ? req1_b : req0_b;
        op_id <= gnt;
        last <= gnt;
      end
      if (state == EXEC) begin
        rsp_data <= sum_y;
        rsp_id <= op_id;
      end
    end
`ifdef FP8_ARB_STATS_EN
  // per-port accept counters, wrapping naturally at 8 bits
  always_ff @(posedge clk)
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (acc) begin
      if (gnt) grant_cnt1 <= grant_cnt1 + 8'd1;
      else grant_cnt0 <= grant_cnt0 + 8'd1;
    end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule
